// File: rtl/mem_port_arbiter.sv
// Two-port (fetch/data) arbiter in front of a single synchronous memory with MEM_LAT read latency.
// Define MEMARB_FAIR_EN to make simultaneous requests alternate; otherwise data has fixed priority.
module mem_port_arbiter #(
  parameter int ADDR_W  = 6,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              memen,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic [5:0]        counter
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t     state_reg;
  logic [2:0] wcnt_reg;
  logic       win_d_reg;
  logic       grant_d;

`ifdef MEMARB_FAIR_EN
  // last_d_reg remembers whether data won the previous grant; it resets to 1 so fetch wins first.
  logic last_d_reg;
  assign grant_d = d_req && !(if_req && last_d_reg);
`else
  assign grant_d = d_req;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      wcnt_reg  <= '0;
      win_d_reg <= 1'b0;
      memen     <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_ack    <= 1'b0;
      d_ack     <= 1'b0;
      if_rdata  <= '0;
      d_rdata   <= '0;
      busy      <= 1'b0;
      counter   <= '0;
`ifdef MEMARB_FAIR_EN
      last_d_reg <= 1'b1;
`endif
    end else begin
      memen  <= 1'b0;
      if_ack <= 1'b0;
      d_ack  <= 1'b0;
      case (state_reg)
        IDLE, DONE: begin
          if (if_req || d_req) begin
            state_reg <= ISSUE;
            busy      <= 1'b1;
            memen     <= 1'b1;
            win_d_reg <= grant_d;
            mem_addr  <= grant_d ? d_addr : if_addr;
            mem_we    <= grant_d && d_we;
            mem_wdata <= grant_d ? d_wdata : '0;
`ifdef MEMARB_FAIR_EN
            last_d_reg <= grant_d;
`endif
          end else begin
            state_reg <= IDLE;
            busy      <= 1'b0;
          end
        end
        ISSUE: begin
          state_reg <= WAIT;
          wcnt_reg  <= 3'(MEM_LAT);
        end
        WAIT: begin
          if (wcnt_reg == 3'd1) begin
            state_reg <= DONE;
            wcnt_reg  <= '0;
            counter   <= counter + 6'd1;
            if (win_d_reg) d_ack  <= 1'b1;
            else           if_ack <= 1'b1;
            // Writes leave both read registers untouched.
            if (!mem_we) begin
              if (win_d_reg) d_rdata  <= mem_rdata;
              else           if_rdata <= mem_rdata;
            end
          end else begin
            wcnt_reg <= wcnt_reg - 3'd1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
